loanio_bridge: RTL and testbench

Parametrised successor to the fixed loan-IO pin map between FPGA fabric and the HPS loan-IO bus (67 pins). It routes N_OUT fabric outputs and N_IN fabric inputs to pin indices chosen by parameter. Outputs are registered, and output enables are held off during a power-up/quiesce settle window. Inputs are synchronised and glitch-filtered, with a falling-edge pulse per input for PS/2-style clocks.

---
 rtl/loanio_pkg.sv | 42 ++++
 rtl/loanio_in_filter.sv | 55 +++++
 rtl/loanio_bridge.sv | 118 +++++++++++
 tb/tb_loanio_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loanio_pkg.sv
// Shared constants, state encoding and the pin-map validity check for the
// parametrised HPS loan-IO bridge.
package loanio_pkg;

  localparam int LOAN_W = 67;
  localparam int IDX_W  = 7;
  localparam int MAP_W  = LOAN_W * IDX_W;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_e;

  // True when every listed index is < LOAN_W and no pin is claimed twice
  // across both maps (maps are zero-extended to MAP_W by the caller).
  function automatic logic map_valid(input logic [MAP_W-1:0] out_map, input int n_out,
                                     input logic [MAP_W-1:0] in_map, input int n_in);
    logic [LOAN_W-1:0] used;
    logic              ok;
    int                idx;
    used = '0;
    ok   = 1'b1;
    for (int i = 0; i < LOAN_W; i++) begin
      if (i < n_out) begin
        idx = int'(out_map[IDX_W*i +: IDX_W]);
        if (idx >= LOAN_W) ok = 1'b0;
        else if (used[idx]) ok = 1'b0;
        else used[idx] = 1'b1;
      end
    end
    for (int i = 0; i < LOAN_W; i++) begin
      if (i < n_in) begin
        idx = int'(in_map[IDX_W*i +: IDX_W]);
        if (idx >= LOAN_W) ok = 1'b0;
        else if (used[idx]) ok = 1'b0;
        else used[idx] = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/loanio_in_filter.sv
// One loan-IO input channel: two-flop synchroniser, persistence filter and a
// registered pulse on each filtered 1->0 transition.
module loanio_in_filter import loanio_pkg::*; #(
  parameter int   FILT_LEN  = 4,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic dout_o,
  output logic fall_o
);

  localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

  logic       s1_q, s2_q;
  logic       data_q, data_d;
  logic       fall_q, fall_d;
  logic [7:0] cnt_q, cnt_d;

  // A differing level must be seen FILT_LEN times in a row before it is taken.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (s2_q == data_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == CNT_LAST) begin
      data_d = s2_q;
      cnt_d  = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    fall_d = data_q & ~data_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= RESET_VAL;
      s2_q   <= RESET_VAL;
      data_q <= RESET_VAL;
      cnt_q  <= 8'd0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign dout_o = data_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/loanio_bridge.sv
// Parametrised fabric <-> HPS loan-IO pin map: registered, settle-gated outputs
// and filtered inputs with falling-edge pulses.
module loanio_bridge import loanio_pkg::*; #(
  parameter int                     N_OUT         = 10,
  parameter int                     N_IN          = 2,
  parameter logic [N_OUT*IDX_W-1:0] OUT_MAP       = {7'd48, 7'd17, 7'd19, 7'd33, 7'd34,
                                                     7'd29, 7'd28, 7'd30, 7'd23, 7'd27},
  parameter logic [N_IN*IDX_W-1:0]  IN_MAP        = {7'd53, 7'd54},
  parameter logic [N_IN-1:0]        IN_RESET      = '1,
  parameter int                     FILT_LEN      = 4,
  parameter int                     SETTLE_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_OUT-1:0]  out_data,
  input  logic [N_OUT-1:0]  out_en,
  input  logic              quiesce,
  output logic [N_IN-1:0]   in_data,
  output logic [N_IN-1:0]   in_fall,
  output logic              ready,
  input  logic [LOAN_W-1:0] loan_io_in,
  output logic [LOAN_W-1:0] loan_io_out,
  output logic [LOAN_W-1:0] loan_io_oe
);

  localparam int           SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

  if (N_OUT < 1 || N_OUT > LOAN_W || N_IN < 1 || N_IN > LOAN_W ||
      FILT_LEN < 1 || FILT_LEN > 255 || SETTLE_CYCLES < 1) begin : g_bad_param
    $error("loanio_bridge: channel count, FILT_LEN or SETTLE_CYCLES out of range");
  end else if (!map_valid(MAP_W'(OUT_MAP), N_OUT, MAP_W'(IN_MAP), N_IN)) begin : g_bad_map
    $error("loanio_bridge: pin index out of range, repeated, or shared by OUT_MAP and IN_MAP");
  end

  state_e            state_q, state_d;
  logic [SC_W-1:0]   cnt_q, cnt_d;
  logic              ready_q;
  logic [LOAN_W-1:0] out_q, out_d;
  logic [LOAN_W-1:0] oe_q, oe_d;
  logic              unused_in_s;

  // Settle window: counts quiet cycles, restarts from zero on any quiesce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SETTLE: begin
        if (quiesce) begin
          cnt_d = '0;
        end else if (cnt_q == SC_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SC_W'(1);
        end
      end
      RUN: begin
        if (quiesce) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Scatter channels onto pins; OE is gated with the next state so the pin
  // register and ready change on the same edge.
  always_comb begin
    out_d = '0;
    oe_d  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_d[OUT_MAP[IDX_W*i +: IDX_W]] = out_data[i];
      oe_d[OUT_MAP[IDX_W*i +: IDX_W]]  = out_en[i] & (state_d == RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      out_q   <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
      out_q   <= out_d;
      oe_q    <= oe_d;
    end
  end

  assign ready       = ready_q;
  assign loan_io_out = out_q;
  assign loan_io_oe  = oe_q;
  assign unused_in_s = ^loan_io_in;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    loanio_in_filter #(
      .FILT_LEN  (FILT_LEN),
      .RESET_VAL (IN_RESET[g])
    ) u_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (loan_io_in[IN_MAP[IDX_W*g +: IDX_W]]),
      .dout_o (in_data[g]),
      .fall_o (in_fall[g])
    );
  end

endmodule

// File: tb/tb_loanio_bridge.sv
// Scoreboard bench for loanio_bridge: stimulus queues expected pin/port values
// per sample tick, a negedge monitor pops and compares them.
module tb_loanio_bridge;

  localparam int K_OUT  = 0;
  localparam int K_OE   = 1;
  localparam int K_RDY  = 2;
  localparam int K_IND  = 3;
  localparam int K_FALL = 4;
  localparam logic [66:0] ALL = '1;
  localparam logic [66:0] ONE = 67'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  out_data;
  logic [9:0]  out_en;
  logic        quiesce;
  logic [1:0]  in_data;
  logic [1:0]  in_fall;
  logic        ready;
  logic [66:0] loan_io_in;
  logic [66:0] loan_io_out;
  logic [66:0] loan_io_oe;

  loanio_bridge #(
    .FILT_LEN      (4),
    .SETTLE_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .out_data    (out_data),
    .out_en      (out_en),
    .quiesce     (quiesce),
    .in_data     (in_data),
    .in_fall     (in_fall),
    .ready       (ready),
    .loan_io_in  (loan_io_in),
    .loan_io_out (loan_io_out),
    .loan_io_oe  (loan_io_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    int          kind;
    logic [66:0] mask;
    logic [66:0] val;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   tick   = 0;
  int   checks = 0;
  int   errors = 0;

  // Pin of output channel i (channel 0 is the last entry of the concatenated map).
  int out_pin [10] = '{27, 23, 30, 28, 29, 34, 33, 19, 17, 48};

  function automatic logic [66:0] pins_of(input logic [9:0] v);
    logic [66:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) if (v[i]) r[out_pin[i]] = 1'b1;
    return r;
  endfunction

  function automatic logic [66:0] dut_val(input int kind);
    case (kind)
      K_OUT:   return loan_io_out;
      K_OE:    return loan_io_oe;
      K_RDY:   return {66'd0, ready};
      K_IND:   return {65'd0, in_data};
      K_FALL:  return {65'd0, in_fall};
      default: return '0;
    endcase
  endfunction

  task automatic push(input int at, input int kind, input logic [66:0] mask,
                      input logic [66:0] val, input string nm);
    exp_t e;
    int   idx;
    e.at = at; e.kind = kind; e.mask = mask; e.val = val; e.nm = nm;
    idx = sb_q.size();
    while (idx > 0 && sb_q[idx-1].at > at) idx--;
    sb_q.insert(idx, e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic [66:0] act;
    forever begin
      @(negedge clk);
      tick = tick + 1;
      while (sb_q.size() > 0 && sb_q[0].at <= tick) begin
        e      = sb_q.pop_front();
        act    = dut_val(e.kind) & e.mask;
        checks = checks + 1;
        if (e.at != tick || act !== e.val) begin
          errors = errors + 1;
          $display("FAIL %s tick=%0d(due %0d): got %h expected %h", e.nm, tick, e.at, act, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int b;
    int t0;
    logic [66:0] m48;
    logic [66:0] m27;
    m48 = ONE << 48;
    m27 = ONE << 27;
    rst_n = 1'b0; quiesce = 1'b0; out_data = 10'h2AA; out_en = 10'h3FF; loan_io_in = '1;

    step(3);
    checks = checks + 1;
    if (ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL direct_rst_ready: got %b expected 0", ready);
    end
    checks = checks + 1;
    if (loan_io_oe !== 67'd0) begin
      errors = errors + 1;
      $display("FAIL direct_rst_oe: got %h expected 0", loan_io_oe);
    end
    checks = checks + 1;
    if (in_data !== 2'b11) begin
      errors = errors + 1;
      $display("FAIL direct_rst_in_data: got %b expected 11", in_data);
    end
    push(tick + 1, K_RDY,  ONE, 67'd0, "rst_ready");
    push(tick + 1, K_OE,   ALL, 67'd0, "rst_oe");
    push(tick + 1, K_OUT,  ALL, 67'd0, "rst_out");
    push(tick + 1, K_IND,  ALL, 67'h3, "rst_in_data");
    push(tick + 1, K_FALL, ALL, 67'd0, "rst_in_fall");
    step(1);

    // Power-up settle: sample b+e shows the state after edge e.
    rst_n = 1'b1;
    b = tick + 1;
    push(b + 1,  K_OUT, ALL, pins_of(10'h2AA), "pwr_out_e1");
    push(b + 1,  K_OE,  ALL, 67'd0, "pwr_oe_e1");
    push(b + 15, K_OE,  ALL, 67'd0, "pwr_oe_e15");
    push(b + 15, K_RDY, ONE, 67'd0, "pwr_ready_e15");
    push(b + 16, K_RDY, ONE, 67'd1, "pwr_ready_e16");
    push(b + 16, K_OE,  ALL, pins_of(10'h3FF), "pwr_oe_e16");
    step(16);
    checks = checks + 1;
    if (ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL direct_pwr_ready: got %b expected 1", ready);
    end
    checks = checks + 1;
    if (loan_io_oe !== pins_of(10'h3FF)) begin
      errors = errors + 1;
      $display("FAIL direct_pwr_oe: got %h expected %h", loan_io_oe, pins_of(10'h3FF));
    end

    // One-cycle output latency on pins 48 and 27.
    out_data = 10'h0AA;
    push(tick + 1, K_OUT, m48, m48,   "lat48_before");
    push(tick + 2, K_OUT, m48, 67'd0, "lat48_after");
    step(1);
    out_data = 10'h0AB;
    push(tick + 1, K_OUT, m27, 67'd0, "lat27_before");
    push(tick + 2, K_OUT, m27, m27,   "lat27_after");
    step(1);
    out_data = 10'h155; out_en = 10'h00F;
    push(tick + 2, K_OUT, ALL, pins_of(10'h155), "pattern_out");
    push(tick + 2, K_OE,  ALL, pins_of(10'h00F), "pattern_oe");
    step(2);

    // 3-cycle bounce on both input pins never reaches in_data.
    t0 = tick + 2;
    loan_io_in[54:53] = 2'b00;
    for (int j = 0; j < 10; j++) begin
      push(t0 + j, K_IND,  ALL, 67'h3, "bounce_in_data");
      push(t0 + j, K_FALL, ALL, 67'd0, "bounce_in_fall");
    end
    step(3);
    loan_io_in[54:53] = 2'b11;
    step(9);

    // Sustained low: in_data falls after edge k+5 with a one-cycle in_fall.
    t0 = tick + 2;
    loan_io_in[54:53] = 2'b00;
    push(t0 + 4, K_IND,  ALL, 67'h3, "fall_in_data_k4");
    push(t0 + 4, K_FALL, ALL, 67'd0, "fall_pulse_k4");
    push(t0 + 5, K_IND,  ALL, 67'd0, "fall_in_data_k5");
    push(t0 + 5, K_FALL, ALL, 67'h3, "fall_pulse_k5");
    push(t0 + 6, K_FALL, ALL, 67'd0, "fall_pulse_k6");
    step(8);

    // Rising level: same latency, no fall pulse.
    t0 = tick + 2;
    loan_io_in[54:53] = 2'b11;
    push(t0 + 4, K_IND,  ALL, 67'd0, "rise_in_data_k4");
    push(t0 + 5, K_IND,  ALL, 67'h3, "rise_in_data_k5");
    push(t0 + 5, K_FALL, ALL, 67'd0, "rise_no_fall_k5");
    push(t0 + 6, K_FALL, ALL, 67'd0, "rise_no_fall_k6");
    step(8);

    // Quiesce for 5 edges; outputs keep tracking, ready returns 16 edges later.
    push(tick + 1, K_RDY, ONE, 67'd1, "q_pre_ready");
    quiesce = 1'b1; out_data = 10'h3FF; out_en = 10'h3FF;
    t0 = tick + 2;
    push(t0,     K_RDY, ONE, 67'd0, "q_ready_low");
    push(t0,     K_OE,  ALL, 67'd0, "q_oe_low");
    push(t0,     K_OUT, ALL, pins_of(10'h3FF), "q_out_tracks_hi");
    push(t0 + 4, K_OE,  ALL, 67'd0, "q_oe_low_k4");
    step(2);
    out_data = 10'h000;
    push(tick + 2, K_OUT, ALL, 67'd0, "q_out_tracks_lo");
    step(3);
    quiesce = 1'b0;
    push(t0 + 19, K_RDY, ONE, 67'd0, "q_ready_k19");
    push(t0 + 19, K_OE,  ALL, 67'd0, "q_oe_k19");
    push(t0 + 20, K_RDY, ONE, 67'd1, "q_ready_k20");
    push(t0 + 20, K_OE,  ALL, pins_of(10'h3FF), "q_oe_k20");
    step(22);

    // Drive inputs low, then pulse rst_n for half a cycle in RUN.
    loan_io_in[54:53] = 2'b00;
    push(tick + 7, K_IND, ALL, 67'd0, "pre_rst_in_data");
    step(8);
    push(tick + 1, K_OE,   ALL, 67'd0, "arst_oe");
    push(tick + 1, K_RDY,  ONE, 67'd0, "arst_ready");
    push(tick + 1, K_IND,  ALL, 67'h3, "arst_in_data");
    push(tick + 1, K_FALL, ALL, 67'd0, "arst_in_fall");
    push(tick + 1, K_OUT,  ALL, 67'd0, "arst_out");
    rst_n = 1'b0;
    #5;
    rst_n = 1'b1;
    b = tick;
    push(b + 5,  K_IND,  ALL, 67'h3, "post_rst_in_data_e5");
    push(b + 6,  K_IND,  ALL, 67'd0, "post_rst_in_data_e6");
    push(b + 6,  K_FALL, ALL, 67'h3, "post_rst_in_fall_e6");
    push(b + 15, K_RDY,  ONE, 67'd0, "post_rst_ready_e15");
    push(b + 16, K_RDY,  ONE, 67'd1, "post_rst_ready_e16");
    push(b + 16, K_OE,   ALL, pins_of(10'h3FF), "post_rst_oe_e16");
    step(18);

    for (int w = 0; w < 50 && sb_q.size() > 0; w++) @(posedge clk);
    while (sb_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL %s: expectation due at tick %0d never checked, now %0d", sb_q[0].nm, sb_q[0].at, tick);
      void'(sb_q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
